uart_reg_tx_module: RTL and testbench

Transmit-side counterpart of the UART register receiver. Accepts a REG_WIDTH-bit word over a valid/ready handshake and sends it as consecutive 8N1 UART frames, most-significant byte first. After the last byte it holds the line idle for IDLE_CYCLE bit times, so the far-end register receiver sees a frame boundary. Bit timing is generated internally; no separate bit-level module is required.

---
 rtl/uart_reg_tx_module.sv | 190 +++++++++++++++++++
 tb/tb_uart_reg_tx_module.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_tx_module.sv
// rtl/uart_reg_tx_module.sv - register-word UART transmitter (8N1, MSB byte first, idle gap)
//
// Takes one REG_WIDTH-bit word over a valid/ready handshake and serialises it as
// NBYTES consecutive UART frames, most-significant byte first. Each frame is a
// start bit, 8 data bits LSB first, and a stop bit. After the last frame the line
// stays high for IDLE_CYCLE bit times so a register receiver can find the word
// boundary.
//
// Optional build macro:
//   UART_TX_STOP2_EN  defined -> two stop bits per frame (11-bit frames)
//                     undefined -> one stop bit (10-bit frames)
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   tx_reg_valid  in   tx_reg holds a word to send
//   tx_reg        in   word to transmit (captured on accept)
//   tx_reg_ready  out  block can accept a word this cycle
//   tx_busy       out  word in flight, including the idle gap
//   tx_done       out  one-cycle pulse when a word completes
//   uart_tx       out  serial line, idle high

module uart_reg_tx_module #(
    parameter int CLK_FRE    = 50,
    parameter int BPS        = 115200,
    parameter int IDLE_CYCLE = 20,
    parameter int REG_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_reg_valid,
    input  logic [REG_WIDTH-1:0] tx_reg,
    output logic                 tx_reg_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 uart_tx
);

    localparam int CPB    = CLK_FRE * 1000000 / BPS;
    localparam int NBYTES = REG_WIDTH / 8;
`ifdef UART_TX_STOP2_EN
    localparam int STOP_CYC = 2 * CPB;
`else
    localparam int STOP_CYC = CPB;
`endif
    localparam int GAP_CYC = IDLE_CYCLE * CPB;

    localparam int CNT_W  = $clog2(STOP_CYC + 1);
    localparam int GAP_W  = $clog2(GAP_CYC + 1);
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]     byte_idx_q, byte_idx_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [REG_WIDTH-1:0]  shift_q, shift_d;

    logic                  uart_tx_q, uart_tx_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [7:0]            cur_byte_d;

    // Next-state logic. Counters default to zero so that every state entry
    // starts them from a clean value; only the owning state advances them.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = '0;
        bit_idx_d  = '0;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = '0;
        shift_d    = shift_q;

        case (state_q)
            S_IDLE: begin
                if (tx_reg_valid) begin
                    state_d    = S_START;
                    shift_d    = tx_reg;
                    byte_idx_d = '0;
                end
            end
            S_START: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                bit_idx_d = bit_idx_q;
                if (bit_cnt_q == BIT_LAST) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = S_STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_cnt_q == STOP_LAST) begin
                    if (byte_idx_q == BYTE_LAST) begin
                        state_d = S_GAP;
                    end else begin
                        // Next byte goes straight into its start bit; the
                        // word is left-shifted so the active byte stays on top.
                        state_d    = S_START;
                        byte_idx_d = byte_idx_q + 1'b1;
                        shift_d    = shift_q << 8;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so the line
    // reflects a state change in the same cycle the state register does.
    always_comb begin
        cur_byte_d = shift_d[REG_WIDTH-1 -: 8];
        uart_tx_d  = 1'b1;
        case (state_d)
            S_START: uart_tx_d = 1'b0;
            S_DATA:  uart_tx_d = cur_byte_d[bit_idx_d];
            default: uart_tx_d = 1'b1;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_GAP) && (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            gap_cnt_q  <= '0;
            shift_q    <= '0;
            uart_tx_q  <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            shift_q    <= shift_d;
            uart_tx_q  <= uart_tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign uart_tx      = uart_tx_q;
    assign tx_reg_ready = ready_q;
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;

endmodule

// File: tb/tb_uart_reg_tx_module.sv
// tb/tb_uart_reg_tx_module.sv - self-checking bench for uart_reg_tx_module

module tb_uart_reg_tx_module;

    localparam int CF    = 1;
    localparam int BAUD  = 250000;
    localparam int IC    = 3;
    localparam int RW    = 32;
    localparam int CPB   = CF * 1000000 / BAUD;
    localparam int NB    = RW / 8;
`ifdef UART_TX_STOP2_EN
    localparam int STOPB = 2;
`else
    localparam int STOPB = 1;
`endif
    localparam int FRAME = 9 + STOPB;
    localparam int T     = NB * FRAME * CPB + IC * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_reg_valid = 1'b0;
    logic [RW-1:0] tx_reg = '0;
    logic          tx_reg_ready;
    logic          tx_busy;
    logic          tx_done;
    logic          uart_tx;

    int vectors     = 0;
    int miscompares = 0;

    uart_reg_tx_module #(
        .CLK_FRE   (CF),
        .BPS       (BAUD),
        .IDLE_CYCLE(IC),
        .REG_WIDTH (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_reg_valid(tx_reg_valid),
        .tx_reg      (tx_reg),
        .tx_reg_ready(tx_reg_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .uart_tx     (uart_tx)
    );

    always #5 clk = ~clk;

    // Expected line level s cycles after the accepting edge, from the frame
    // format: start 0, 8 data bits LSB first, stop bit(s) 1, then the idle gap.
    function automatic logic exp_line(input logic [RW-1:0] w, input int s);
        int byte_cyc;
        int b;
        int pos;
        logic [RW-1:0] sh;
        logic [7:0] by;
        byte_cyc = FRAME * CPB;
        if (s >= NB * byte_cyc) return 1'b1;
        b   = s / byte_cyc;
        pos = (s % byte_cyc) / CPB;
        sh  = w >> (8 * (NB - 1 - b));
        by  = sh[7:0];
        if (pos == 0) return 1'b0;
        if (pos <= 8) return by[pos-1];
        return 1'b1;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".uart_tx"}, RW'(uart_tx), RW'(1));
        chk({tag, ".ready"},   RW'(tx_reg_ready), RW'(1));
        chk({tag, ".busy"},    RW'(tx_busy), RW'(0));
        chk({tag, ".done"},    RW'(tx_done), RW'(0));
    endtask

    // Caller presents valid=1 with tx_reg=w while the DUT is idle.
    // abort_at >= 0 applies a one-cycle reset at that sample offset.
    task automatic run_word(input logic [RW-1:0] w, input bit chain,
                            input logic [RW-1:0] nw, input int abort_at);
        step;
        for (int s = 0; s < T; s++) begin
            if (s != 0) step;
            chk("line", RW'(uart_tx), RW'(exp_line(w, s)));
            chk("busy", RW'(tx_busy), RW'(1));
            chk("ready_busy", RW'(tx_reg_ready), RW'(0));
            chk("done_early", RW'(tx_done), RW'(0));
            if (s == abort_at) begin
                rst          = 1'b1;
                tx_reg_valid = 1'b0;
                step;
                rst = 1'b0;
                chk_idle("after_rst");
                return;
            end
            tx_reg       = RW'($urandom);
            tx_reg_valid = 1'($urandom_range(0, 1));
        end
        tx_reg_valid = chain;
        tx_reg       = nw;
        step;
        chk("done", RW'(tx_done), RW'(1));
        chk("ready_done", RW'(tx_reg_ready), RW'(1));
        chk("busy_done", RW'(tx_busy), RW'(0));
        chk("line_done", RW'(uart_tx), RW'(1));
        if (!chain) tx_reg_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step;
            chk_idle(tag);
        end
    endtask

    initial begin
        logic [RW-1:0] w;
        logic [RW-1:0] w2;

        // reset values
        rst = 1'b1;
        step;
        chk_idle("reset");
        rst = 1'b0;
        idle_cycles(2, "post_reset");

        // directed word
        tx_reg_valid = 1'b1;
        tx_reg       = 32'h12345678;
        run_word(32'h12345678, 1'b0, '0, -1);
        idle_cycles(2, "gap1");

        // random words
        for (int k = 0; k < 3; k++) begin
            w            = RW'($urandom);
            tx_reg_valid = 1'b1;
            tx_reg       = w;
            run_word(w, 1'b0, '0, -1);
            idle_cycles(1 + k, "gap_rand");
        end

        // back-to-back with valid held
        tx_reg_valid = 1'b1;
        tx_reg       = 32'hA5A5A5A5;
        run_word(32'hA5A5A5A5, 1'b1, 32'h0000FFFF, -1);
        run_word(32'h0000FFFF, 1'b0, '0, -1);
        idle_cycles(2, "gap_b2b");

        // reset during DATA of the second byte
        w            = RW'($urandom);
        tx_reg_valid = 1'b1;
        tx_reg       = w;
        run_word(w, 1'b0, '0, FRAME * CPB + 3 * CPB);
        idle_cycles(IC * CPB + 4, "no_done");

        tx_reg_valid = 1'b1;
        tx_reg       = 32'hDEADBEEF;
        run_word(32'hDEADBEEF, 1'b0, '0, -1);
        idle_cycles(2, "gap_dead");

        // reset and valid together: reset wins
        rst          = 1'b1;
        tx_reg_valid = 1'b1;
        tx_reg       = 32'hCAFEF00D;
        step;
        chk_idle("rst_valid");
        rst          = 1'b0;
        tx_reg_valid = 1'b0;
        step;
        chk_idle("rst_valid_noacc");

        // random chained pair
        w            = RW'($urandom);
        w2           = RW'($urandom);
        tx_reg_valid = 1'b1;
        tx_reg       = w;
        run_word(w, 1'b1, w2, -1);
        run_word(w2, 1'b0, '0, -1);
        idle_cycles(2, "final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
